// File: rtl/cpu_pkg.sv
// Shared CPU definitions: divider state encoding and divider timing constants.
package cpu_pkg;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned DIV_LAT   = 36;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_ITERS);

  // 3-bit divider state encodings
  localparam logic [2:0] DIV_ENC_IDLE = 3'd0;
  localparam logic [2:0] DIV_ENC_NEGA = 3'd1;
  localparam logic [2:0] DIV_ENC_NEGB = 3'd2;
  localparam logic [2:0] DIV_ENC_ITER = 3'd3;
  localparam logic [2:0] DIV_ENC_FIXQ = 3'd4;
  localparam logic [2:0] DIV_ENC_FIXR = 3'd5;
  localparam logic [2:0] DIV_ENC_DONE = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = DIV_ENC_IDLE,
    S_NEGA = DIV_ENC_NEGA,
    S_NEGB = DIV_ENC_NEGB,
    S_ITER = DIV_ENC_ITER,
    S_FIXQ = DIV_ENC_FIXQ,
    S_FIXR = DIV_ENC_FIXR,
    S_DONE = DIV_ENC_DONE
  } div_state_e;

endpackage

// File: rtl/div_32_seq.sv
// Sequential 32-bit restoring divider (DIV/DIVU) driving the shared adder.
// Ports:
//   clk, clr_n             clock, synchronous active-low reset
//   start, is_signed       request and signedness, sampled in IDLE
//   dividend, divisor      operands, sampled with start
//   busy, done, dz         status; done is a one-cycle pulse, dz = divide by zero
//   lo, hi                 quotient / remainder, held until overwritten
//   add_own                shared-adder mux select (equals busy)
//   add_a, add_b, add_cin  shared-adder operands, zero when idle
//   add_sum, add_cout      shared-adder result, same cycle
module div_32_seq
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             add_own,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  div_state_e             state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]       q_q, q_d, r_q, r_d, m_q, m_d;
  logic [WIDTH-1:0]       lo_q, lo_d, hi_q, hi_d;
  logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic                   dz_q, dz_d, busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]       r_shift;
  logic                   accept;

  // Remainder shifted left with the next dividend bit; R[31] is the 33rd bit.
  assign r_shift = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign accept  = r_q[WIDTH-1] | add_cout;

  // Shared-adder port mux per state; idle states release the adder with zeros.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      S_NEGA: begin add_b = ~a_q; add_cin = 1'b1; end
      S_NEGB: begin add_b = ~b_q; add_cin = 1'b1; end
      S_ITER: begin add_a = r_shift; add_b = ~m_q; add_cin = 1'b1; end
      S_FIXQ: begin add_b = ~q_q; add_cin = 1'b1; end
      S_FIXR: begin add_b = ~r_q; add_cin = 1'b1; end
      default: ;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    q_d     = q_q;
    r_d     = r_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = dividend;
          b_d     = divisor;
          sgn_d   = is_signed;
          cnt_d   = '0;
          dz_d    = 1'b0;
          state_d = S_NEGA;
        end
      end
      S_NEGA: begin
        q_d     = (sgn_q && a_q[WIDTH-1]) ? add_sum : a_q;
        r_d     = '0;
        qneg_d  = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_d  = sgn_q & a_q[WIDTH-1];
        state_d = S_NEGB;
      end
      S_NEGB: begin
        m_d     = (sgn_q && b_q[WIDTH-1]) ? add_sum : b_q;
        state_d = S_ITER;
      end
      S_ITER: begin
        // Zero divisor is caught on the first pass, before any result is formed.
        if (cnt_q == '0 && m_q == '0) begin
          dz_d    = 1'b1;
          lo_d    = '1;
          hi_d    = a_q;
          state_d = S_DONE;
        end else begin
          r_d   = accept ? add_sum : r_shift;
          q_d   = {q_q[WIDTH-2:0], accept};
          cnt_d = cnt_q + DIV_CNT_W'(1);
          if (cnt_q == DIV_CNT_W'(DIV_ITERS - 1)) state_d = S_FIXQ;
        end
      end
      S_FIXQ: begin
        lo_d    = qneg_q ? add_sum : q_q;
        state_d = S_FIXR;
      end
      S_FIXR: begin
        hi_d    = rneg_q ? add_sum : r_q;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      q_q     <= q_d;
      r_q     <= r_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign add_own = busy_q;
  assign done    = done_q;
  assign dz      = dz_q;
  assign lo      = lo_q;
  assign hi      = hi_q;

endmodule
